// File: rtl/bus_width_increase.sv
// -----------------------------------------------------------------------------
// bus_width_increase
//   Gathers consecutive SIZE_IN-bit beats into one SIZE_OUT-bit word, with
//   valid/ready handshakes on both sides. A beat flagged input_last closes a
//   partially filled word early: the unfilled lanes stay zero and the number
//   of beats actually written is reported in output_beats.
//
//   Storage is one assembly register plus one output register. When a word
//   completes while the output register is still occupied, the finished word
//   parks in the assembly register (pend) and input_ready drops until the
//   sink takes the held word. input_ready is derived only from registered
//   state, so there is no combinational path from output_ready.
// -----------------------------------------------------------------------------
module bus_width_increase #(
    parameter int  SIZE_IN       = 8,
    parameter int  SIZE_OUT      = 32,
    parameter bit  LITTLE_ENDIAN = 1'b1,
    localparam int RATIO         = SIZE_OUT / SIZE_IN,
    localparam int CW            = $clog2(RATIO) + 1
) (
    input  logic                clk,
    input  logic                rst_n,

    output logic                input_ready,
    input  logic                input_valid,
    input  logic [SIZE_IN-1:0]  data_in,
    input  logic                input_last,

    output logic                output_valid,
    input  logic                output_ready,
    output logic [SIZE_OUT-1:0] data_out,
    output logic [CW-1:0]       output_beats,
    output logic                output_last
);

    // Refuse to elaborate when the wide bus is not a whole number of lanes.
    if ((SIZE_OUT % SIZE_IN) != 0 || SIZE_OUT < SIZE_IN) begin : g_bad_ratio
        $error("bus_width_increase: SIZE_OUT (%0d) must be a multiple of SIZE_IN (%0d)",
               SIZE_OUT, SIZE_IN);
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [SIZE_OUT-1:0] asm_data,   asm_data_nxt;
    logic [CW-1:0]       cnt,        cnt_nxt;
    logic                pend,       pend_nxt;
    logic [CW-1:0]       pend_beats, pend_beats_nxt;
    logic                pend_last,  pend_last_nxt;

    logic [SIZE_OUT-1:0] out_data,   out_data_nxt;
    logic [CW-1:0]       out_beats,  out_beats_nxt;
    logic                out_last,   out_last_nxt;
    logic                out_vld,    out_vld_nxt;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic                in_fire;
    logic                out_fire;
    logic                beat_final;
    logic [CW-1:0]       lane;
    logic [CW-1:0]       cnt_inc;
    logic [SIZE_OUT-1:0] merged;

    assign input_ready  = !pend;
    assign output_valid = out_vld;
    assign data_out     = out_data;
    assign output_beats = out_beats;
    assign output_last  = out_last;

    assign in_fire    = input_valid && !pend;
    assign out_fire   = out_vld && output_ready;
    assign cnt_inc    = cnt + 1'b1;
    assign beat_final = (cnt == CW'(RATIO - 1)) || input_last;

    // Lane addressed by the current beat: lane 0 first for little endian,
    // top lane first otherwise.
    always_comb begin
        if (LITTLE_ENDIAN) begin
            lane = cnt;
        end else begin
            lane = CW'(RATIO - 1) - cnt;
        end
    end

    // Assembly word with the current beat dropped into its lane; lanes not yet
    // written are still zero because asm_data is cleared after every word.
    always_comb begin
        merged = asm_data;
        for (int l = 0; l < RATIO; l++) begin
            if (lane == CW'(l)) begin
                merged[l*SIZE_IN +: SIZE_IN] = data_in;
            end
        end
    end

    // Next-state decision for assembly, pending and output registers.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        asm_data_nxt   = asm_data;
        cnt_nxt        = cnt;
        pend_nxt       = pend;
        pend_beats_nxt = pend_beats;
        pend_last_nxt  = pend_last;
        out_data_nxt   = out_data;
        out_beats_nxt  = out_beats;
        out_last_nxt   = out_last;
        out_vld_nxt    = out_vld;

        if (pend) begin
            // Input is stalled; the parked word moves out on the next transfer
            // and the output register stays valid.
            if (out_fire) begin
                out_data_nxt  = asm_data;
                out_beats_nxt = pend_beats;
                out_last_nxt  = pend_last;
                out_vld_nxt   = 1'b1;
                pend_nxt      = 1'b0;
                cnt_nxt       = '0;
                asm_data_nxt  = '0;
            end
        end else begin
            if (out_fire) begin
                out_vld_nxt = 1'b0;
            end

            if (in_fire) begin
                if (!beat_final) begin
                    asm_data_nxt = merged;
                    cnt_nxt      = cnt_inc;
                end else if (!out_vld || out_fire) begin
                    // Output register is free (or drains this cycle): the
                    // word goes straight out.
                    out_data_nxt  = merged;
                    out_beats_nxt = cnt_inc;
                    out_last_nxt  = input_last;
                    out_vld_nxt   = 1'b1;
                    cnt_nxt       = '0;
                    asm_data_nxt  = '0;
                end else begin
                    // Output register busy: park the finished word.
                    asm_data_nxt   = merged;
                    pend_nxt       = 1'b1;
                    pend_beats_nxt = cnt_inc;
                    pend_last_nxt  = input_last;
                end
            end
        end
    end

    // State registers; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data registers are reset as well as the control flags,
        // because a flush relies on asm_data starting at zero for its padding.
        if (!rst_n) begin
            asm_data   <= '0;
            cnt        <= '0;
            pend       <= 1'b0;
            pend_beats <= '0;
            pend_last  <= 1'b0;
            out_data   <= '0;
            out_beats  <= '0;
            out_last   <= 1'b0;
            out_vld    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the same pre-edge state.
            asm_data   <= asm_data_nxt;
            cnt        <= cnt_nxt;
            pend       <= pend_nxt;
            pend_beats <= pend_beats_nxt;
            pend_last  <= pend_last_nxt;
            out_data   <= out_data_nxt;
            out_beats  <= out_beats_nxt;
            out_last   <= out_last_nxt;
            out_vld    <= out_vld_nxt;
        end
    end

endmodule

// File: tb/tb_bus_width_increase.sv
// -----------------------------------------------------------------------------
// tb_bus_width_increase
//   Two instances (little and big endian) share one input stream. A negedge
//   monitor feeds accepted beats to a queue-based word model and compares every
//   transferred word; directed sections cover fill, flush, backpressure,
//   random streaming and an asynchronous reset in mid-word.
// -----------------------------------------------------------------------------
module tb_bus_width_increase;

    localparam int SIZE_IN  = 8;
    localparam int SIZE_OUT = 32;
    localparam int RATIO    = SIZE_OUT / SIZE_IN;
    localparam int CW       = $clog2(RATIO) + 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                input_valid;
    logic [SIZE_IN-1:0]  data_in;
    logic                input_last;
    logic                output_ready;

    logic                input_ready,  input_ready_be;
    logic                output_valid, output_valid_be;
    logic [SIZE_OUT-1:0] data_out,     data_out_be;
    logic [CW-1:0]       output_beats, output_beats_be;
    logic                output_last,  output_last_be;

    int n_checks = 0;
    int n_fail   = 0;
    bit rnd_ready = 1'b0;

    always #5 clk = ~clk;

    bus_width_increase #(.SIZE_IN(SIZE_IN), .SIZE_OUT(SIZE_OUT), .LITTLE_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .input_ready(input_ready), .input_valid(input_valid),
        .data_in(data_in), .input_last(input_last),
        .output_valid(output_valid), .output_ready(output_ready),
        .data_out(data_out), .output_beats(output_beats), .output_last(output_last)
    );

    bus_width_increase #(.SIZE_IN(SIZE_IN), .SIZE_OUT(SIZE_OUT), .LITTLE_ENDIAN(1'b0)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .input_ready(input_ready_be), .input_valid(input_valid),
        .data_in(data_in), .input_last(input_last),
        .output_valid(output_valid_be), .output_ready(output_ready),
        .data_out(data_out_be), .output_beats(output_beats_be), .output_last(output_last_be)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: beats collected per word, words queued until taken.
    // ---------------------------------------------------------------------
    typedef struct {
        logic [SIZE_OUT-1:0] le;
        logic [SIZE_OUT-1:0] be;
        int                  beats;
        bit                  last;
    } word_t;

    logic [SIZE_IN-1:0] cur[$];
    word_t              q[$];
    word_t              mon_w;

    function automatic word_t build_word(input bit last);
        word_t w;
        w.le = '0;
        w.be = '0;
        for (int i = 0; i < cur.size(); i++) begin
            w.le = w.le | (SIZE_OUT'(cur[i]) << (i * SIZE_IN));
            w.be = w.be | (SIZE_OUT'(cur[i]) << ((RATIO - 1 - i) * SIZE_IN));
        end
        w.beats = cur.size();
        w.last  = last;
        return w;
    endfunction

    // Monitor: signals are stable at negedge, so this sees what the next
    // posedge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur.delete();
            q.delete();
        end else begin
            check("output_valid_state", output_valid, q.size() != 0);
            check("input_ready_state", input_ready, q.size() < 2);
            if (output_valid && output_ready && q.size() != 0) begin
                mon_w = q.pop_front();
                check("word_le", data_out, mon_w.le);
                check("word_be", data_out_be, mon_w.be);
                check("word_beats", output_beats, mon_w.beats);
                check("word_beats_be", output_beats_be, mon_w.beats);
                check("word_last", output_last, mon_w.last);
            end
            if (input_valid && input_ready) begin
                cur.push_back(data_in);
                if (cur.size() == RATIO || input_last) begin
                    q.push_back(build_word(input_last));
                    cur.delete();
                end
            end
        end
    end

    // Present one beat and hold it until accepted; returns 1 ns after the
    // accepting edge. Called 1 ns after a posedge.
    task automatic send(input logic [SIZE_IN-1:0] d, input bit last);
        bit done;
        done        = 1'b0;
        input_valid = 1'b1;
        data_in     = d;
        input_last  = last;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (input_ready) begin
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rnd_ready) output_ready = 1'($urandom_range(0, 1));
        end
        if (!done) check("send_timeout", 1'b0, 1'b1);
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        input_valid  = 1'b0;
        data_in      = '0;
        input_last   = 1'b0;
        output_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_output_valid", output_valid, 1'b0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_output_beats", output_beats, 0);
        check("rst_output_last", output_last, 1'b0);
        check("rst_input_ready", input_ready, 1'b1);
        #2 rst_n = 1'b1;
        tick();
        output_ready = 1'b1;

        // Fill one full word
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        check("fill_ready_mid", input_ready, 1'b1);
        send(8'h44, 1'b0);
        check("fill_valid", output_valid, 1'b1);
        check("fill_data", data_out, 32'h44332211);
        check("fill_data_be", data_out_be, 32'h11223344);
        check("fill_beats", output_beats, 4);
        check("fill_last", output_last, 1'b0);
        check("fill_ready", input_ready, 1'b1);
        tick();
        check("fill_drained", output_valid, 1'b0);

        // Early flush, then a full word starting again at lane 0
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        check("flush_data", data_out, 32'h0000BBAA);
        check("flush_data_be", data_out_be, 32'hAABB0000);
        check("flush_beats", output_beats, 2);
        check("flush_last", output_last, 1'b1);
        send(8'hC1, 1'b1);
        check("flush1_data", data_out, 32'h000000C1);
        check("flush1_beats", output_beats, 1);
        for (int i = 0; i < RATIO; i++) send(8'hE1 + 8'(i), 1'b0);
        check("after_flush_data", data_out, 32'hE4E3E2E1);
        tick();

        // Backpressure: two full words with the sink stalled
        output_ready = 1'b0;
        for (int i = 1; i <= 2 * RATIO; i++) send(8'(i), 1'b0);
        check("bp_input_ready", input_ready, 1'b0);
        check("bp_output_valid", output_valid, 1'b1);
        check("bp_hold_data", data_out, 32'h04030201);
        output_ready = 1'b1;
        tick();
        check("bp_second_valid", output_valid, 1'b1);
        check("bp_second_data", data_out, 32'h08070605);
        check("bp_ready_back", input_ready, 1'b1);
        tick();
        check("bp_empty", output_valid, 1'b0);

        // Random streaming with random gaps and a random sink
        rnd_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                output_ready = 1'($urandom_range(0, 1));
            end
            send(8'($urandom), $urandom_range(0, 5) == 0);
        end
        rnd_ready    = 1'b0;
        output_ready = 1'b1;
        repeat (RATIO + 2) tick();
        check("stream_flushed_words", q.size(), 0);

        // Complete the partial word left by the random phase
        while (cur.size() != 0) send(8'h5A, 1'b1);
        repeat (2) tick();

        // Asynchronous reset mid-word with a word held in the output register
        output_ready = 1'b0;
        for (int i = 0; i < RATIO; i++) send(8'hF0 + 8'(i), 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_output_valid", output_valid, 1'b0);
        check("arst_input_ready", input_ready, 1'b1);
        check("arst_data_out", data_out, 32'h0);
        #3 rst_n = 1'b1;
        output_ready = 1'b1;
        tick();
        check("arst_nothing_emitted", output_valid, 1'b0);
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b0);
        send(8'hD4, 1'b0);
        check("arst_word", data_out, 32'hD4D3D2D1);
        check("arst_beats", output_beats, 4);
        tick();
        check("arst_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
